// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit id encodings, flit field positions and a width helper.
package noc_pkg;

  localparam int unsigned FLIT_ID_W = 3;
  localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

  // Field MSBs given as bit offsets below the flit MSB (DATA_WIDTH-1).
  localparam int unsigned FLIT_ID_MSB = 0;
  localparam int unsigned LEN_MSB     = 3;
  localparam int unsigned LEN_W       = 12;

  typedef enum logic {
    OPA_IDLE,
    OPA_LOCKED
  } opa_state_e;

  // Ceiling log2 with a minimum of one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping modulo NUM_IN.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN = 5
) (
  input  logic [NUM_IN-1:0]        req,
  input  logic [clog2(NUM_IN)-1:0] ptr,
  output logic [NUM_IN-1:0]        gnt,
  output logic [clog2(NUM_IN)-1:0] idx
);

  localparam int unsigned IDX_W = clog2(NUM_IN);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      pos = (32'(ptr) + k >= NUM_IN) ? IDX_W'(32'(ptr) + k - NUM_IN) : IDX_W'(32'(ptr) + k);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_alloc.sv
// Output-port allocator: round-robin header arbitration, wormhole lock by length, credit flow control.
// Optional stall watchdog enabled with `define NOC_OPA_WATCHDOG_EN.
module noc_out_port_alloc
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN      = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CREDITS     = 4,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_flit,
  output logic [NUM_IN-1:0]            grant,
  output logic [DATA_WIDTH-1:0]        out_flit,
  output logic                         out_valid,
  input  logic                         credit_in,
  output logic                         busy,
  output logic [clog2(NUM_IN)-1:0]     owner,
  output logic [clog2(CREDITS+1)-1:0]  credits,
  output logic                         stall_err
);

  localparam int unsigned IDX_W  = clog2(NUM_IN);
  localparam int unsigned CRD_W  = clog2(CREDITS + 1);
  localparam int unsigned ID_TOP = DATA_WIDTH - 1 - FLIT_ID_MSB;
  localparam int unsigned LEN_TOP = DATA_WIDTH - 1 - LEN_MSB;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  if (NUM_IN < 2 || NUM_IN > 16 || CREDITS < 1 || CREDITS > 255 ||
      WDOG_CYCLES == 0 || WDOG_CYCLES > 65535) begin : g_bad_param
    $error("noc_out_port_alloc: parameter out of range");
  end

  opa_state_e           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [LEN_W-1:0]     remaining;
  logic [NUM_IN-1:0]    hdr_req;
  logic [NUM_IN-1:0]    arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic [NUM_IN-1:0]    grant_c;
  logic                 gnt_any;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic [LEN_W-1:0]     hdr_len;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_IN - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Only header flits may open a new packet.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_hdr
    assign hdr_req[i] = req[i] && (in_flit[i*DATA_WIDTH + ID_TOP -: FLIT_ID_W] == FLIT_HEADER);
  end

  noc_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req (hdr_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grant decode from registered state only; credit_in never reaches grant.
  always_comb begin
    grant_c = '0;
    if (!rst && credits != '0) begin
      if (state == OPA_LOCKED) grant_c[owner] = req[owner];
      else                     grant_c = arb_gnt;
    end
  end

  assign grant   = grant_c;
  assign gnt_any = |grant_c;

  always_comb begin
    sel_flit = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_c[i]) sel_flit = in_flit[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign hdr_len = sel_flit[LEN_TOP -: LEN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OPA_IDLE;
      rr_ptr    <= '0;
      remaining <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      credits   <= CRD_MAX;
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) out_flit <= sel_flit;

      // Simultaneous grant and returned credit cancel; a return at full is dropped.
      if (gnt_any && !credit_in)
        credits <= credits - CRD_W'(1);
      else if (!gnt_any && credit_in && credits != CRD_MAX)
        credits <= credits + CRD_W'(1);

      case (state)
        OPA_IDLE: begin
          if (gnt_any) begin
            if (hdr_len <= LEN_W'(1)) begin
              rr_ptr <= wrap_inc(arb_idx);
            end else begin
              state     <= OPA_LOCKED;
              busy      <= 1'b1;
              owner     <= arb_idx;
              remaining <= hdr_len - LEN_W'(1);
            end
          end
        end
        OPA_LOCKED: begin
          if (gnt_any) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state  <= OPA_IDLE;
              busy   <= 1'b0;
              owner  <= '0;
              rr_ptr <= wrap_inc(owner);
            end
          end
        end
        default: state <= OPA_IDLE;
      endcase
    end
  end

`ifdef NOC_OPA_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(WDOG_CYCLES);

  logic [15:0] wd_cnt;

  // Counts locked cycles without progress; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else if (state == OPA_LOCKED && !gnt_any) begin
      if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt + 16'd1 == WD_LIMIT) stall_err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Bench for noc_out_port_alloc: directed vector table, corner sequences, random traffic vs reference model.
module tb_noc_out_port_alloc;
  import noc_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CR = 4;
  localparam int unsigned WD = 8;
  localparam int unsigned IW = clog2(N);
  localparam int unsigned CW = clog2(CR + 1);
`ifdef NOC_OPA_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] in_flit = '0;
  logic [N-1:0]    grant;
  logic [DW-1:0]   out_flit;
  logic            out_valid;
  logic            credit_in = 1'b0;
  logic            busy;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   credits;
  logic            stall_err;

  noc_out_port_alloc #(
    .NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .in_flit(in_flit), .grant(grant),
    .out_flit(out_flit), .out_valid(out_valid), .credit_in(credit_in),
    .busy(busy), .owner(owner), .credits(credits), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_flit(input logic [2:0] id, input int unsigned len,
                                            input int unsigned tag);
    return {id, 12'(len), 17'(tag)};
  endfunction

  // Reference model: packet-level view of the port.
  int            m_lock, m_rem, m_ptr, m_cr, m_wd;
  logic          m_ov, m_err;
  logic [DW-1:0] m_of;

  function automatic int m_pick();
    logic [DW-1:0] f;
    if (m_cr == 0) return -1;
    if (m_lock >= 0) return req[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      f = in_flit[i*DW +: DW];
      if (req[i] && f[DW-1 -: 3] == FLIT_HEADER) return i;
    end
    return -1;
  endfunction

  task automatic m_step(input int g);
    bit was_locked;
    int len;
    was_locked = (m_lock >= 0);
    if (g >= 0) begin
      m_ov = 1'b1;
      m_of = in_flit[g*DW +: DW];
      len  = int'(m_of[DW-4 -: 12]);
      if (!was_locked) begin
        if (len <= 1) m_ptr = (g + 1) % N;
        else begin m_lock = g; m_rem = len - 1; end
      end else begin
        m_rem--;
        if (m_rem == 0) begin m_ptr = (g + 1) % N; m_lock = -1; end
      end
    end else begin
      m_ov = 1'b0;
    end
    if (g >= 0 && !credit_in) m_cr--;
    else if (g < 0 && credit_in && m_cr < CR) m_cr++;
    if (was_locked && g < 0) begin
      if (m_wd < WD) m_wd++;
      if (m_wd == WD) m_err = WD_EN;
    end else begin
      m_wd = 0;
    end
  endtask

  // One clock with model check; inputs must already be driven.
  task automatic tick(output int g);
    #1;
    g = m_pick();
    check("grant", 64'(grant), (g < 0) ? 64'd0 : (64'd1 << g));
    m_step(g);
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_flit", 64'(out_flit), 64'(m_of));
    check("busy", 64'(busy), 64'(m_lock >= 0));
    check("owner", 64'(owner), (m_lock < 0) ? 64'd0 : 64'(m_lock));
    check("credits", 64'(credits), 64'(m_cr));
    check("stall_err", 64'(stall_err), 64'(m_err));
  endtask

  task automatic do_reset();
    req = '0; in_flit = '0; credit_in = 1'b0; rst = 1'b1;
    m_lock = -1; m_rem = 0; m_ptr = 0; m_cr = CR; m_ov = 1'b0; m_of = '0; m_wd = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_credits", 64'(credits), 64'(CR));
    check("rst_stall_err", 64'(stall_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] hdr;
    int unsigned  len;
    logic         cin;
    logic [N-1:0] g;
    logic         busy;
    int unsigned  own;
    int unsigned  crd;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  logic [DW-1:0] fq[N][$];

  initial begin
    int g;
    logic [DW-1:0] ef;

    //            req       hdr     len cin  grant   busy own crd
    tbl[0]  = '{5'b00101, 5'b00101, 1, 1'b0, 5'b00001, 1'b0, 0, 3};
    tbl[1]  = '{5'b00100, 5'b00100, 1, 1'b0, 5'b00100, 1'b0, 0, 2};
    tbl[2]  = '{5'b00101, 5'b00101, 1, 1'b1, 5'b00001, 1'b0, 0, 2};
    tbl[3]  = '{5'b00101, 5'b00101, 1, 1'b1, 5'b00100, 1'b0, 0, 2};
    tbl[4]  = '{5'b00000, 5'b00000, 1, 1'b1, 5'b00000, 1'b0, 0, 3};
    tbl[5]  = '{5'b00000, 5'b00000, 1, 1'b1, 5'b00000, 1'b0, 0, 4};
    tbl[6]  = '{5'b00010, 5'b00010, 3, 1'b0, 5'b00010, 1'b1, 1, 3};
    tbl[7]  = '{5'b01010, 5'b01000, 3, 1'b0, 5'b00010, 1'b1, 1, 2};
    tbl[8]  = '{5'b01010, 5'b01000, 3, 1'b0, 5'b00010, 1'b0, 0, 1};
    tbl[9]  = '{5'b01000, 5'b01000, 1, 1'b1, 5'b01000, 1'b0, 0, 1};
    tbl[10] = '{5'b00001, 5'b00000, 1, 1'b0, 5'b00000, 1'b0, 0, 1};
    tbl[11] = '{5'b10000, 5'b10000, 4, 1'b0, 5'b10000, 1'b1, 4, 0};
    tbl[12] = '{5'b10000, 5'b00000, 4, 1'b1, 5'b00000, 1'b1, 4, 1};
    tbl[13] = '{5'b10000, 5'b00000, 4, 1'b0, 5'b10000, 1'b1, 4, 0};
    tbl[14] = '{5'b10000, 5'b00000, 4, 1'b1, 5'b00000, 1'b1, 4, 1};
    tbl[15] = '{5'b10000, 5'b00000, 4, 1'b1, 5'b10000, 1'b1, 4, 1};
    tbl[16] = '{5'b10000, 5'b00000, 4, 1'b0, 5'b10000, 1'b0, 0, 0};
    tbl[17] = '{5'b00001, 5'b00001, 1, 1'b0, 5'b00000, 1'b0, 0, 0};
    tbl[18] = '{5'b00001, 5'b00001, 1, 1'b1, 5'b00000, 1'b0, 0, 1};
    tbl[19] = '{5'b00001, 5'b00001, 1, 1'b0, 5'b00001, 1'b0, 0, 0};

    do_reset();

    // Directed vectors: arbitration, wormhole lock, credit stall.
    for (int v = 0; v < NV; v++) begin
      req = tbl[v].req;
      credit_in = tbl[v].cin;
      for (int i = 0; i < N; i++)
        in_flit[i*DW +: DW] = mk_flit(tbl[v].hdr[i] ? FLIT_HEADER : FLIT_BODY, tbl[v].len,
                                      32'(v * 8 + i));
      #1;
      check($sformatf("tbl%0d_grant", v), 64'(grant), 64'(tbl[v].g));
      ef = '0;
      for (int i = 0; i < N; i++) if (tbl[v].g[i]) ef = in_flit[i*DW +: DW];
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out_valid", v), 64'(out_valid), 64'(|tbl[v].g));
      if (|tbl[v].g) check($sformatf("tbl%0d_out_flit", v), 64'(out_flit), 64'(ef));
      check($sformatf("tbl%0d_busy", v), 64'(busy), 64'(tbl[v].busy));
      check($sformatf("tbl%0d_owner", v), 64'(owner), 64'(tbl[v].own));
      check($sformatf("tbl%0d_credits", v), 64'(credits), 64'(tbl[v].crd));
    end

    // Non-header flit at a FIFO head is never granted in IDLE.
    do_reset();
    req = 5'b00001;
    in_flit[0 +: DW] = mk_flit(FLIT_BODY, 2, 7);
    repeat (20) tick(g);
    check("nonhdr_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-packet aborts the lock immediately.
    do_reset();
    req = 5'b00100;
    in_flit[2*DW +: DW] = mk_flit(FLIT_HEADER, 4, 1);
    tick(g);
    in_flit[2*DW +: DW] = mk_flit(FLIT_BODY, 0, 2);
    tick(g);
    check("mid_busy_before", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_grant", 64'(grant), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_flit", 64'(out_flit), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_owner", 64'(owner), 64'd0);
    check("mid_credits", 64'(credits), 64'(CR));
    req = 5'b10000;
    in_flit[4*DW +: DW] = mk_flit(FLIT_HEADER, 1, 3);
    m_lock = -1; m_rem = 0; m_ptr = 0; m_cr = CR; m_ov = 1'b0; m_of = '0; m_wd = 0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_new_grant", 64'(grant), 64'h10);
    tick(g);

    // Owner stalls for WD cycles; flag is sticky when traffic resumes.
    do_reset();
    req = 5'b00001;
    in_flit[0 +: DW] = mk_flit(FLIT_HEADER, 3, 9);
    tick(g);
    req = '0;
    repeat (WD) tick(g);
    check("wdog_flag", 64'(stall_err), 64'(WD_EN));
    req = 5'b00001;
    in_flit[0 +: DW] = mk_flit(FLIT_TAIL, 0, 10);
    repeat (3) tick(g);
    check("wdog_sticky", 64'(stall_err), 64'(WD_EN));

    // Random packet traffic with downstream credit returns.
    do_reset();
    for (int i = 0; i < N; i++) fq[i].delete();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (fq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = int'($urandom_range(0, 5));
          fq[i].push_back(mk_flit(FLIT_HEADER, 32'(len), $urandom_range(0, 131071)));
          for (int k = 1; k < len; k++)
            fq[i].push_back(mk_flit((k == len - 1) ? FLIT_TAIL : FLIT_BODY,
                                    $urandom_range(0, 4095), $urandom_range(0, 131071)));
        end
        req[i] = (fq[i].size() > 0) && ($urandom_range(0, 4) != 0);
        in_flit[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : DW'($urandom);
      end
      credit_in = (m_cr < CR) && ($urandom_range(0, 2) == 0);
      tick(g);
      if (g >= 0) void'(fq[g].pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
